// File: rtl/mdu_unit.sv
// mdu_unit: execute-stage multiply/divide unit with private HI/LO registers.
// Multi-cycle mult/multu/div/divu, mfhi/mflo reads, and mthi/mtlo writes.
// busy goes to the hazard unit.
// Optional feature macro: MDU_MADD_EN enables madd (9) and maddu (10).
// These accumulate a signed or unsigned product into {HI,LO}.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    logic [31:0]   hi_q, lo_q, a_q, b_q;
    logic [3:0]    op_q;
    logic [CW-1:0] cnt;

    logic [63:0] prod_s, prod_u;
    logic [31:0] mag_a, mag_b, quo_s, rem_s, quo_u, rem_u;
    logic [31:0] res_hi, res_lo;
    logic        res_wr;
    logic        start_ok, start_div;

    assign busy = (cnt != '0);
    assign HI   = hi_q;
    assign LO   = lo_q;

    // mfhi/mflo read port, zero latency
    always_comb begin
        out = 32'd0;
        if (MDUOp == OP_MFHI)
            out = hi_q;
        else if (MDUOp == OP_MFLO)
            out = lo_q;
    end

    // Decide whether a start pulse carries an op this unit accepts
    always_comb begin
        start_ok  = 1'b0;
        start_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
        case (MDUOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: start_ok = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU:                  start_ok = 1'b1;
`endif
            default:                            start_ok = 1'b0;
        endcase
    end

    // Result datapath from latched operands.
    // Signed divide works on magnitudes, so 0x80000000 / -1 yields 0x80000000 without overflow.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        mag_a  = a_q[31] ? -a_q : a_q;
        mag_b  = b_q[31] ? -b_q : b_q;
        quo_s  = 32'd0;
        rem_s  = 32'd0;
        quo_u  = 32'd0;
        rem_u  = 32'd0;
        if (mag_b != 32'd0) begin
            quo_s = mag_a / mag_b;
            rem_s = mag_a % mag_b;
        end
        if (b_q != 32'd0) begin
            quo_u = a_q / b_q;
            rem_u = a_q % b_q;
        end
        res_hi = hi_q;
        res_lo = lo_q;
        res_wr = 1'b0;
        case (op_q)
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_wr = 1'b1;
            end
            OP_DIV: begin
                // divide by zero leaves HI/LO untouched
                if (b_q != 32'd0) begin
                    res_lo = (a_q[31] ^ b_q[31]) ? -quo_s : quo_s;
                    res_hi = a_q[31] ? -rem_s : rem_s;
                    res_wr = 1'b1;
                end
            end
            OP_DIVU: begin
                if (b_q != 32'd0) begin
                    res_lo = quo_u;
                    res_hi = rem_u;
                    res_wr = 1'b1;
                end
            end
`ifdef MDU_MADD_EN
            // accumulate against HI/LO as held at the completion edge
            OP_MADD: begin
                {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
                res_wr = 1'b1;
            end
            OP_MADDU: begin
                {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
                res_wr = 1'b1;
            end
`endif
            default: res_wr = 1'b0;
        endcase
    end

    // Busy countdown, operand latch, result writeback and mthi/mtlo
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            op_q <= 4'd0;
            cnt  <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && res_wr) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else if (start && start_ok) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= MDUOp;
            cnt  <= start_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (MDUOp == OP_MTHI) begin
            hi_q <= A;
        end else if (MDUOp == OP_MTLO) begin
            lo_q <= A;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit.
// Stimulus pushes the expected HI/LO for each busy operation.
// A negedge monitor pops and compares the entry when busy falls.
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] out, HI, LO;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    logic busy_d = 1'b0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
        .A(A), .B(B), .busy(busy), .out(out), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: a busy falling edge marks a completed operation
    always @(negedge clk) begin
        if (reset) begin
            busy_d = 1'b0;
        end else begin
            if (busy_d && !busy) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk({e.name, "_hi"}, HI, e.hi);
                    chk({e.name, "_lo"}, LO, e.lo);
                end
            end
            busy_d = busy;
        end
    end

    // Issue one busy op, check the busy window, and optionally inject illegal traffic.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] ehi,
                          input logic [31:0] elo, input bit inj);
        exp_t e;
        @(negedge clk);
        chk({name, "_busy_start"}, {31'd0, busy}, 32'd0);
        start = 1'b1; MDUOp = op; A = a; B = b;
        e.name = name; e.hi = ehi; e.lo = elo;
        sb_q.push_back(e);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            start = 1'b0; MDUOp = 4'd0;
            if (inj && i == 2) begin
                start = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd7;
            end
            if (inj && i == 3) begin
                MDUOp = 4'd8; A = 32'h0000DEAD;
            end
            chk({name, "_busy"}, {31'd0, busy}, 32'd1);
        end
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 4'd0;
        chk({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        MDUOp = op; A = a;
        @(posedge clk); #1;
        MDUOp = 4'd0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; MDUOp = 4'd0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state and read port
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        MDUOp = 4'd5; #1 chk("rst_mfhi", out, 32'd0);
        MDUOp = 4'd6; #1 chk("rst_mflo", out, 32'd0);
        MDUOp = 4'd0;

        run_op("mult_neg",  4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
        run_op("multu",     4'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, 0);
        run_op("multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, 0);
        run_op("mult_min",  4'd1, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000, 0);
        run_op("div_neg",   4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("divu_zero", 4'd4, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("div_ovf",   4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 0);
        run_op("divu",      4'd4, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC, 0);
        run_op("div_negb",  4'd3, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, 0);

        // mthi/mtlo with readback through out
        move_to(4'd7, 32'h12345678);
        chk("mthi_hi", HI, 32'h12345678);
        MDUOp = 4'd5; #1 chk("mfhi_out", out, 32'h12345678);
        MDUOp = 4'd0; #1 chk("none_out", out, 32'd0);
        move_to(4'd8, 32'hCAFEF00D);
        chk("mtlo_lo", LO, 32'hCAFEF00D);
        MDUOp = 4'd6; #1 chk("mflo_out", out, 32'hCAFEF00D);
        MDUOp = 4'd0;

        // start and mtlo while busy are ignored
        run_op("mult_inj", 4'd1, 32'd2, 32'd3, 5, 32'd0, 32'd6, 1);
        chk("inj_no_extra_busy", {31'd0, busy}, 32'd0);

        // madd
        move_to(4'd7, 32'd0);
        move_to(4'd8, 32'd10);
`ifdef MDU_MADD_EN
        run_op("madd", 4'd9, 32'd4, 32'd5, 5, 32'd0, 32'd30, 0);
`else
        @(negedge clk);
        start = 1'b1; MDUOp = 4'd9; A = 32'd4; B = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 4'd0;
        for (int i = 0; i < 3; i++) begin
            chk("madd_off_busy", {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
        end
        chk("madd_off_lo", LO, 32'd10);
`endif

        // reset mid-divide: busy drops at once, HI/LO clear
        move_to(4'd7, 32'h55AA55AA);
        @(negedge clk);
        start = 1'b1; MDUOp = 4'd3; A = 32'd50; B = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 4'd0;
        @(posedge clk); @(posedge clk); #1;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        repeat (12) @(posedge clk);
        #1 chk("post_rst_hi", HI, 32'd0);

        // back-to-back after reset
        run_op("mult_after_rst", 4'd2, 32'd6, 32'd7, 5, 32'd0, 32'd42, 0);

        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Execute-stage multiply/divide unit of the five-stage MIPS pipeline. It consumes the E-stage operands and the `start`/`MDUOp` control fields produced by the D→E pipeline register. It performs multi-cycle multiply/divide into private HI/LO registers, serves mfhi/mflo/mthi/mtlo, and exports `busy` to the hazard unit for stalling.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd/maddu).
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk` in 1: clock. One clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse from E register; high only with a mult/div-class `MDUOp`.
- `MDUOp` in 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu; 11–15 none.
- `A` in 32: rs operand (forwarded E_V1).
- `B` in 32: rt operand (forwarded E_V2).
- `busy` out 1: operation in progress.
- `out` out 32: combinational HI when `MDUOp`=5, LO when 6, else 0.
- `HI` out 32: current HI register (debug).
- `LO` out 32: current LO register (debug).

## Operation
- State: `HI`, `LO`, down-counter `cnt`, latched operands and op, and pending result `resHI`/`resLO`.
- Idle (`cnt`=0) with `start`=1 and op 1–4/9–10:
  - Latch A, B and op.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - Result is computed from the latched values.
- Busy (`cnt`≠0): decrement each edge. On the edge where `cnt`=1, write HI/LO and `cnt`→0.
- `busy` = (`cnt`≠0). It is registered, so it is low in the `start` cycle. The hazard unit stalls on `start | busy`.
- mult: {HI,LO} = signed 64-bit A×B. multu: unsigned product.
- div: LO = A/B, HI = A%B, signed. Quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu is the unsigned version.
- Divide by zero: full DIV_CYCLES busy period, then HI/LO left unchanged.
- mthi (7): HI←A at the next edge. mtlo (8): LO←B... no: LO←A at the next edge. Both apply only when `cnt`=0.
- mfhi/mflo: pure reads, no state change.
- Illegal while busy: `start` or mthi/mtlo are ignored. The pipeline guarantees this never happens.
- `start` with op 0, 5–8 or 11–15: ignored.

## Timing
- Reset values: `HI`=0, `LO`=0, `cnt`=0, `busy`=0, `out`=0, latched operands and op 0. Reset takes effect immediately, without waiting for a clock edge.
- Reset mid-operation: the pending result is discarded, `busy` drops at once, and HI/LO read 0.
- Start in cycle t:
  - `busy`=1 in cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES).
  - New HI/LO are visible, and `busy`=0, in cycle t+N+1.
- Back-to-back: a new `start` is accepted in cycle t+N+1.
- mthi/mtlo in cycle t: visible on `HI`/`LO`/`out` in cycle t+1.
- `out` has zero latency relative to `MDUOp` and the registers.

## Configuration
- Macro `MDU_MADD_EN`.
- Defined:
  - Op 9 (madd): {HI,LO} ← {HI,LO} + signed A×B, mod 2^64.
  - Op 10 (maddu): same with an unsigned product.
  - The accumulate uses HI/LO as held at the completion edge.
  - Latency is MULT_CYCLES.
- Undefined: ops 9 and 10 behave as op 0. `start` with them is ignored and `busy` stays 0.

## Test plan
- Reset, then `MDUOp`=5 and 6 → `out`=0 both. Assert `reset` mid-div → `busy`=0 immediately, HI=LO=0.
- mult, A=0xFFFFFFFE (−2), B=3, start at t:
  - `busy` high for t+1..t+5.
  - t+6: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div, A=0xFFFFFFF9 (−7), B=2:
  - `busy` for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu, A=7, B=0 → HI/LO unchanged after 10 busy cycles.
- mthi A=0x12345678 at t → `HI`=0x12345678 at t+1. Then `MDUOp`=5 → `out`=0x12345678. mtlo while `busy` → LO unchanged.
- `start` during busy of a mult (A=2, B=3) with div operands → ignored; result HI=0, LO=6 at the original time.
- With `MDU_MADD_EN`: HI=0, LO=10; madd A=4, B=5 → after 5 cycles LO=30. Without the macro, the same stimulus gives `busy`=0 and LO=10.
